// File: rtl/ssr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ssr_pkg
// Brief    : Shared state encoding and default parameter values for the
//            speech-recognition decision controller.
// Revision : 1.0
// ============================================================================
package ssr_pkg;

    localparam int DEF_NUM_CLASSES   = 4;
    localparam int DEF_VOTE_DEPTH    = 5;
    localparam int DEF_LISTEN_CYCLES = 100000000;
    localparam int DEF_HOLD_CYCLES   = 50000000;
    localparam int DEF_DEB_CYCLES    = 1000000;
    localparam int DEF_MIN_VOTES     = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LISTEN = 2'd1,
        ST_DECIDE = 2'd2,
        ST_SHOW   = 2'd3
    } ssr_state_t;

endpackage : ssr_pkg
`default_nettype wire

// File: rtl/ssr_debounce.sv
`default_nettype none
// ============================================================================
// Module   : ssr_debounce
// Brief    : Two-flop synchroniser, stability counter and one-cycle pulse on
//            each debounced rising edge of an asynchronous push button.
// Revision : 1.0
// ============================================================================
module ssr_debounce
    import ssr_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic but,
    output logic press
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic [CW-1:0] cnt;

    // The synchronised level must disagree with the accepted level for
    // DEB_CYCLES consecutive samples before it is taken as the new level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync1 <= but;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= sync2;
                cnt    <= '0;
                press  <= sync2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule : ssr_debounce
`default_nettype wire

// File: rtl/ssr_decision_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ssr_decision_ctrl
// Brief    : Button-armed listening window that majority-votes classifier
//            results and shows the winner on a one-hot LED bank for a hold
//            time. Macro SSR_MIN_VOTES_EN rejects winners below MIN_VOTES.
// Revision : 1.0
// ============================================================================
module ssr_decision_ctrl
    import ssr_pkg::*;
#(
    parameter int NUM_CLASSES   = DEF_NUM_CLASSES,
    parameter int CLASS_W       = $clog2(NUM_CLASSES),
    parameter int VOTE_DEPTH    = DEF_VOTE_DEPTH,
    parameter int LISTEN_CYCLES = DEF_LISTEN_CYCLES,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
    parameter int MIN_VOTES     = DEF_MIN_VOTES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   but,
    input  logic                   class_valid,
    input  logic [CLASS_W-1:0]     class_idx,
    output logic [NUM_CLASSES-1:0] led,
    output logic                   busy,
    output logic                   result_valid,
    output logic [CLASS_W-1:0]     result_idx,
    output logic                   no_result
);

    localparam int HW  = $clog2(VOTE_DEPTH + 1);
    localparam int TW  = (LISTEN_CYCLES > 1) ? $clog2(LISTEN_CYCLES) : 1;
    localparam int HTW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [HW-1:0]  LAST_VOTE   = HW'(VOTE_DEPTH - 1);
    localparam logic [TW-1:0]  LISTEN_LAST = TW'(LISTEN_CYCLES - 1);
    localparam logic [HTW-1:0] HOLD_LAST   = HTW'(HOLD_CYCLES - 1);

    ssr_state_t state;
    ssr_state_t state_next;

    logic                   press;
    logic                   enter_listen;
    logic                   count_vote;
    logic [NUM_CLASSES-1:0] hit_vec;

    logic [HW-1:0]          hist [NUM_CLASSES];
    logic [HW-1:0]          votes;
    logic [TW-1:0]          timer;
    logic [HTW-1:0]         hold;

    logic [CLASS_W-1:0]     win_idx;
    logic [HW-1:0]          win_cnt;
    logic                   win_none;
    logic [CLASS_W-1:0]     res_idx_q;
    logic                   no_res_q;

    ssr_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_debounce (
        .clk   (clk),
        .rst   (rst),
        .but   (but),
        .press (press)
    );

    // A class index with no matching bin leaves hit_vec empty, so it is dropped.
    for (genvar g = 0; g < NUM_CLASSES; g++) begin : g_hit
        assign hit_vec[g] = (class_idx == CLASS_W'(g));
    end

    assign count_vote = (state == ST_LISTEN) && class_valid && (|hit_vec);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Leaving LISTEN looks at the vote arriving this cycle so the decision
    // strobe follows the last counted vote by exactly one cycle.
    always_comb begin
        state_next   = state;
        enter_listen = 1'b0;
        busy         = 1'b0;
        result_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                if (press) begin
                    state_next   = ST_LISTEN;
                    enter_listen = 1'b1;
                end
            end
            ST_LISTEN: begin
                busy = 1'b1;
                if ((count_vote && (votes == LAST_VOTE)) || (timer == LISTEN_LAST)) begin
                    state_next = ST_DECIDE;
                end
            end
            ST_DECIDE: begin
                busy         = 1'b1;
                result_valid = 1'b1;
                state_next   = ST_SHOW;
            end
            ST_SHOW: begin
                if (press) begin
                    state_next   = ST_LISTEN;
                    enter_listen = 1'b1;
                end else if (hold == HOLD_LAST) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                hist[i] <= '0;
            end
            votes <= '0;
            timer <= '0;
        end else if (enter_listen) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                hist[i] <= '0;
            end
            votes <= '0;
            timer <= '0;
        end else if (state == ST_LISTEN) begin
            timer <= timer + TW'(1);
            if (count_vote) begin
                votes <= votes + HW'(1);
                for (int i = 0; i < NUM_CLASSES; i++) begin
                    if (hit_vec[i]) begin
                        hist[i] <= hist[i] + HW'(1);
                    end
                end
            end
        end
    end

    // Strict greater-than keeps the lowest index on ties.
    always_comb begin
        win_idx = '0;
        win_cnt = hist[0];
        for (int i = 1; i < NUM_CLASSES; i++) begin
            if (hist[i] > win_cnt) begin
                win_idx = CLASS_W'(i);
                win_cnt = hist[i];
            end
        end
    end

`ifdef SSR_MIN_VOTES_EN
    assign win_none = (votes == '0) || (int'(win_cnt) < MIN_VOTES);
`else
    logic unused_min_votes;
    assign win_none         = (votes == '0);
    assign unused_min_votes = ^MIN_VOTES;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_idx_q <= '0;
            no_res_q  <= 1'b0;
            hold      <= '0;
        end else if (state == ST_DECIDE) begin
            res_idx_q <= win_idx;
            no_res_q  <= win_none;
            hold      <= '0;
        end else if (state == ST_SHOW) begin
            hold <= hold + HTW'(1);
        end
    end

    // The fresh decision is presented during DECIDE; the registered copy holds it afterwards.
    assign result_idx = (state == ST_DECIDE) ? win_idx  : res_idx_q;
    assign no_result  = (state == ST_DECIDE) ? win_none : no_res_q;

    for (genvar g = 0; g < NUM_CLASSES; g++) begin : g_led
        assign led[g] = (state == ST_SHOW) && !no_res_q && (res_idx_q == CLASS_W'(g));
    end

endmodule : ssr_decision_ctrl
`default_nettype wire

// File: tb/tb_ssr_decision_ctrl.sv
`default_nettype none
// Scoreboard bench for ssr_decision_ctrl: directed stimulus pushes expected
// decisions; a negedge monitor pops them on result_valid and checks the LEDs.
module tb_ssr_decision_ctrl;

    localparam int NC = 4;
    localparam int CW = 3;
    localparam int VD = 5;
    localparam int LC = 200;
    localparam int HC = 50;
    localparam int DC = 4;
    localparam int MV = 3;
`ifdef SSR_MIN_VOTES_EN
    localparam bit MINV = 1'b1;
`else
    localparam bit MINV = 1'b0;
`endif

    logic          clk         = 1'b0;
    logic          rst         = 1'b0;
    logic          but         = 1'b0;
    logic          class_valid = 1'b0;
    logic [CW-1:0] class_idx   = '0;
    logic [NC-1:0] led;
    logic          busy;
    logic          result_valid;
    logic [CW-1:0] result_idx;
    logic          no_result;

    typedef struct {
        int idx;
        bit nores;
        bit hold;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    ssr_decision_ctrl #(
        .NUM_CLASSES   (NC),
        .CLASS_W       (CW),
        .VOTE_DEPTH    (VD),
        .LISTEN_CYCLES (LC),
        .HOLD_CYCLES   (HC),
        .DEB_CYCLES    (DC),
        .MIN_VOTES     (MV)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .but          (but),
        .class_valid  (class_valid),
        .class_idx    (class_idx),
        .led          (led),
        .busy         (busy),
        .result_valid (result_valid),
        .result_idx   (result_idx),
        .no_result    (no_result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_press(output bit ok);
        ok  = 1'b0;
        but = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (busy) begin
                ok = 1'b1;
                break;
            end
        end
        but = 1'b0;
    endtask

    task automatic vote(input int idx);
        class_valid = 1'b1;
        class_idx   = CW'(idx);
        @(posedge clk);
        #1;
        class_valid = 1'b0;
    endtask

    task automatic wait_result(input string name, input int exp_cycles, input longint t0);
        int cycles;
        cycles = -1;
        for (int i = 0; i < 400; i++) begin
            if (result_valid) begin
                cycles = int'((longint'($time) - t0) / 10);
                break;
            end
            @(posedge clk);
            #1;
        end
        chk(name, cycles, exp_cycles);
    endtask

    task automatic push(input int idx, input bit nores, input bit hold);
        exp_t e;
        e.idx   = idx;
        e.nores = nores;
        e.hold  = hold;
        exp_q.push_back(e);
    endtask

    // Monitor: pops one expectation per decision strobe, then checks the display.
    initial begin
        exp_t          e;
        logic [NC-1:0] exp_led;
        forever begin
            @(negedge clk);
            if (rst && result_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("result_no_result", no_result, e.nores);
                    if (!e.nores) begin
                        chk("result_idx", result_idx, e.idx);
                    end
                    exp_led = e.nores ? '0 : (NC'(1) << e.idx);
                    @(negedge clk);
                    chk("led_show_first", led, exp_led);
                    if (e.hold) begin
                        repeat (HC - 1) @(negedge clk);
                        chk("led_show_last", led, exp_led);
                        @(negedge clk);
                        chk("led_after_hold", led, 0);
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit     ok;
        bit     seen;
        longint t0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_led", led, 0);
        chk("rst_busy", busy, 0);
        chk("rst_result_valid", result_valid, 0);
        chk("rst_result_idx", result_idx, 0);
        chk("rst_no_result", no_result, 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a listening window.
        do_press(ok);
        chk("s1_press", ok, 1);
        vote(2);
        vote(2);
        repeat (3) @(posedge clk);
        #4;
        rst = 1'b0;
        #1;
        chk("s1_rst_busy", busy, 0);
        chk("s1_rst_led", led, 0);
        chk("s1_rst_result_valid", result_valid, 0);
        chk("s1_rst_result_idx", result_idx, 0);
        chk("s1_rst_no_result", no_result, 0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        repeat (10) @(posedge clk);
        #1;

        // Clear majority reached by vote depth.
        push(2, 1'b0, 1'b1);
        do_press(ok);
        chk("s2_press", ok, 1);
        vote(2); vote(2); vote(1); vote(2); vote(3);
        chk("s2_vote_latency", result_valid, 1);
        repeat (HC + 10) @(posedge clk);
        #1;

        // Tie resolved to the lowest index after the listen timeout.
        push(1, MINV, 1'b1);
        do_press(ok);
        chk("s3_press", ok, 1);
        t0 = longint'($time);
        vote(1); vote(3); vote(3); vote(1);
        wait_result("s3_timeout_latency", LC, t0);
        repeat (HC + 10) @(posedge clk);
        #1;

        // No votes at all.
        push(0, 1'b1, 1'b1);
        do_press(ok);
        chk("s4_press", ok, 1);
        t0 = longint'($time);
        wait_result("s4_empty_latency", LC, t0);
        chk("s4_no_result", no_result, 1);
        repeat (HC + 10) @(posedge clk);
        #1;

        // Short glitch must not arm; out-of-range class must not count.
        but = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        but  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            seen = seen | busy;
        end
        chk("s5_glitch_ignored", seen, 0);
        push(1, 1'b0, 1'b1);
        do_press(ok);
        chk("s5_press", ok, 1);
        vote(5); vote(1); vote(5); vote(1); vote(0); vote(1);
        chk("s5_not_early", result_valid, 0);
        vote(3);
        chk("s5_vote_latency", result_valid, 1);
        repeat (HC + 10) @(posedge clk);
        #1;

        // Spread votes, then a press during SHOW restarts listening.
        push(0, MINV, 1'b0);
        do_press(ok);
        chk("s6_press", ok, 1);
        vote(0); vote(1); vote(2); vote(3); vote(0);
        chk("s6_vote_latency", result_valid, 1);
        repeat (10) @(posedge clk);
        #1;
        do_press(ok);
        chk("s6_restart_listen", ok, 1);
        chk("s6_led_cleared", led, 0);
        t0 = longint'($time);
        push(0, 1'b1, 1'b1);
        wait_result("s6_restart_timeout", LC, t0);
        repeat (HC + 10) @(posedge clk);
        #1;

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_ssr_decision_ctrl
`default_nettype wire
